// File: rtl/cbd_sampler.sv
// CBD (eta = 2) sampler: captures a 1024-bit PRF block and streams 256 coefficients over valid/ready.
// Optional build macro CBD_CENTERED_OUT_EN: emit two's-complement d instead of the mod-Q mapping.
module cbd_sampler #(
    parameter int Q  = 3329,
    parameter int CW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic [1023:0] in,
    output logic [CW-1:0] coeff,
    output logic [7:0]    coeff_index,
    output logic          coeff_valid,
    input  logic          coeff_ready,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [1023:0]   buf_q, buf_d;
    logic [7:0]      idx_q, idx_d;
    logic [CW-1:0]   coeff_q, coeff_d;
    logic            valid_q, valid_d;
    logic            done_q, done_d;

    logic [7:0]      idx_nxt;
    logic [9:0]      nib_base;

    function automatic logic [CW-1:0] cbd_map(input logic [3:0] nib);
        logic        [1:0] a;
        logic        [1:0] b;
        logic signed [2:0] d;
        a = {1'b0, nib[0]} + {1'b0, nib[1]};
        b = {1'b0, nib[2]} + {1'b0, nib[3]};
        d = $signed({1'b0, a}) - $signed({1'b0, b});
`ifdef CBD_CENTERED_OUT_EN
        return {{(CW-3){d[2]}}, d};
`else
        if (d[2]) begin
            return CW'(Q + int'(d));
        end
        return {{(CW-3){1'b0}}, d};
`endif
    endfunction

    assign idx_nxt  = idx_q + 8'd1;
    assign nib_base = {idx_nxt, 2'b00};

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        idx_d   = idx_q;
        coeff_d = coeff_q;
        valid_d = valid_q;
        done_d  = done_q;
        case (state_q)
            IDLE, DONE: begin
                // Restart from DONE behaves exactly like a start from IDLE.
                if (enable) begin
                    buf_d   = in;
                    idx_d   = 8'd0;
                    coeff_d = cbd_map(in[3:0]);
                    valid_d = 1'b1;
                    done_d  = 1'b0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (valid_q && coeff_ready) begin
                    if (idx_q == 8'd255) begin
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_nxt;
                        coeff_d = cbd_map(buf_q[nib_base +: 4]);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            buf_q   <= '0;
            idx_q   <= '0;
            coeff_q <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            idx_q   <= idx_d;
            coeff_q <= coeff_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign coeff       = coeff_q;
    assign coeff_index = idx_q;
    assign coeff_valid = valid_q;
    assign done        = done_q;

endmodule
